// File: rtl/fetch_controller_if.sv
// Instruction-memory request/acknowledge port between the fetch controller
// (master) and the instruction memory (slave).
`timescale 1ns/1ps
interface fetch_controller_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the fetch PC, runs the instruction-memory
// handshake and feeds the fetch/decode register through a one-entry skid.
`timescale 1ns/1ps
module fetch_controller #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  fetch_controller_if.master  imem,
  input  logic                redirect_valid,
  input  logic [WIDTH-1:0]    redirect_pc,
  input  logic                stall,
  output logic                if_valid,
  output logic [WIDTH-1:0]    if_pc,
  output logic [WIDTH-1:0]    if_instr
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] target_pc;
  logic [WIDTH-1:0] skid_pc;
  logic [WIDTH-1:0] skid_instr;
  logic             imem_req_q;

  // Request is a flop updated with the state, so no input reaches the port.
  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BOOT;
      fetch_pc   <= RESET_PC;
      target_pc  <= RESET_PC;
      skid_pc    <= '0;
      skid_instr <= '0;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= '0;
      imem_req_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (redirect_valid) begin
            fetch_pc   <= redirect_pc;
            skid_pc    <= '0;
            skid_instr <= '0;
          end
          if_valid   <= 1'b0;
          state      <= FETCH;
          imem_req_q <= 1'b1;
        end

        FETCH: begin
          if (redirect_valid) begin
            // Redirect beats stall; an in-flight request must still complete.
            if_valid   <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
            if (imem.imem_ack) begin
              fetch_pc <= redirect_pc;
            end else begin
              target_pc <= redirect_pc;
              state     <= DISCARD;
            end
          end else if (imem.imem_ack) begin
            fetch_pc <= fetch_pc + WIDTH'(PC_STEP);
            if (!if_valid || !stall) begin
              if_valid <= 1'b1;
              if_pc    <= fetch_pc;
              if_instr <= imem.imem_rdata;
            end else begin
              skid_pc    <= fetch_pc;
              skid_instr <= imem.imem_rdata;
              state      <= HOLD;
              imem_req_q <= 1'b0;
            end
          end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            if_valid   <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
            fetch_pc   <= redirect_pc;
            state      <= FETCH;
            imem_req_q <= 1'b1;
          end else if (!stall) begin
            if_valid   <= 1'b1;
            if_pc      <= skid_pc;
            if_instr   <= skid_instr;
            state      <= FETCH;
            imem_req_q <= 1'b1;
          end
        end

        DISCARD: begin
          // Old request stays on the bus until acked; its data is dropped.
          if_valid <= 1'b0;
          if (redirect_valid) begin
            target_pc  <= redirect_pc;
            skid_pc    <= '0;
            skid_instr <= '0;
            if (imem.imem_ack) begin
              fetch_pc <= redirect_pc;
              state    <= FETCH;
            end
          end else if (imem.imem_ack) begin
            fetch_pc <= target_pc;
            state    <= FETCH;
          end
        end

        default: begin
          state      <= BOOT;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a program-order reference model.
`timescale 1ns/1ps
module tb_fetch_controller;
  localparam int unsigned WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] STEP     = 32'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_controller_if #(.WIDTH(WIDTH)) bus ();

  fetch_controller #(
    .WIDTH   (WIDTH),
    .RESET_PC(RESET_PC),
    .PC_STEP (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (bus),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_consumed = 0;

  int unsigned ack_pct, stall_pct, redir_pct;
  bit          force_redir = 1'b0;
  logic [31:0] force_rpc = '0;

  // Program-order model: next PC decode should see, next PC memory should serve.
  logic [31:0] exp_fetch, exp_deliver, target;
  bit          discarding;

  // Expectations carried into the next cycle.
  bit          e_wait, e_redirect, e_deliver, e_skid, e_hold, e_disc_done, e_boot, e_after_boot;
  logic [31:0] e_addr, e_rpc, e_pc, e_instr, e_target;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_expect();
    e_wait = 0; e_redirect = 0; e_deliver = 0; e_skid = 0;
    e_hold = 0; e_disc_done = 0; e_boot = 0; e_after_boot = 0;
  endtask

  task automatic body();
    logic        s_req, s_v, ack, stl, rdr, accept;
    logic [31:0] s_addr, s_pc, s_in, rpc;
    s_req  = bus.imem_req;
    s_addr = bus.imem_addr;
    s_v    = if_valid;
    s_pc   = if_pc;
    s_in   = if_instr;

    if (e_boot) begin
      chk("boot_req", 32'(s_req), 32'd0);
      chk("boot_addr", s_addr, RESET_PC);
      chk("boot_valid", 32'(s_v), 32'd0);
    end
    if (e_after_boot) begin
      chk("first_req", 32'(s_req), 32'd1);
      chk("first_addr", s_addr, RESET_PC);
    end
    if (e_wait) begin
      chk("wait_req_held", 32'(s_req), 32'd1);
      chk("wait_addr_held", s_addr, e_addr);
    end
    if (e_redirect) begin
      chk("redirect_flush", 32'(s_v), 32'd0);
      if (!e_wait) begin
        chk("redirect_req", 32'(s_req), 32'd1);
        chk("redirect_addr", s_addr, e_rpc);
      end
    end
    if (e_disc_done) begin
      chk("discard_req", 32'(s_req), 32'd1);
      chk("discard_addr", s_addr, e_target);
    end
    if (e_deliver) begin
      chk("deliver_valid", 32'(s_v), 32'd1);
      chk("deliver_pc", s_pc, e_addr);
      chk("deliver_instr", s_in, mem(e_addr));
    end
    if (e_hold) begin
      chk("hold_valid", 32'(s_v), 32'd1);
      chk("hold_pc", s_pc, e_pc);
      chk("hold_instr", s_in, e_instr);
    end
    if (e_skid) chk("skid_req_off", 32'(s_req), 32'd0);

    // Inputs for this cycle; memory only acks real requests except the late ack at boot.
    ack = e_boot ? 1'b1 : (s_req && ($urandom_range(99) < ack_pct));
    stl = $urandom_range(99) < stall_pct;
    rdr = !e_boot && ($urandom_range(99) < redir_pct);
    rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(1023)) << 2);
    if (force_redir) begin
      rdr = 1'b1;
      rpc = force_rpc;
      force_redir = 1'b0;
    end
    bus.imem_ack   = ack;
    bus.imem_rdata = ack ? mem(s_addr) : $urandom;
    stall          = stl;
    redirect_valid = rdr;
    redirect_pc    = rpc;

    if (s_v && !stl) begin
      chk("consume_pc", s_pc, exp_deliver);
      chk("consume_instr", s_in, mem(s_pc));
      exp_deliver = exp_deliver + STEP;
      n_consumed++;
    end
    accept = s_req && ack && !discarding && !rdr;
    if (accept) begin
      chk("fetch_order", s_addr, exp_fetch);
      exp_fetch = s_addr + STEP;
    end

    e_wait       = s_req && !ack;
    e_addr       = s_addr;
    e_redirect   = rdr;
    e_rpc        = rpc;
    e_deliver    = accept && !(s_v && stl);
    e_skid       = accept && s_v && stl;
    e_hold       = s_v && stl && !rdr;
    e_pc         = s_pc;
    e_instr      = s_in;
    e_disc_done  = s_req && ack && discarding && !rdr;
    e_target     = target;
    e_after_boot = e_boot;
    e_boot       = 1'b0;

    if (rdr) begin
      discarding  = s_req && !ack;
      target      = rpc;
      exp_fetch   = rpc;
      exp_deliver = rpc;
    end else if (s_req && ack && discarding) begin
      discarding = 1'b0;
      exp_fetch  = target;
    end
  endtask

  task automatic step();
    @(negedge clk);
    body();
  endtask

  task automatic do_reset(input bit mid);
    if (mid) begin
      @(posedge clk);
      #2;
    end
    reset          = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = $urandom;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_req", 32'(bus.imem_req), 32'd0);
    reset       = 1'b1;
    exp_fetch   = RESET_PC;
    exp_deliver = RESET_PC;
    target      = RESET_PC;
    discarding  = 1'b0;
    clear_expect();
    e_boot = 1'b1;
    body();
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    clear_expect();
    #3;
    do_reset(1'b0);

    // Back-to-back acks, no stall: one instruction per cycle.
    ack_pct = 100; stall_pct = 0; redir_pct = 0;
    repeat (16) step();
    // Delayed acks.
    ack_pct = 35;
    repeat (60) step();
    // Stalls with ack tied high exercise the skid.
    ack_pct = 100; stall_pct = 60;
    repeat (80) step();
    // Everything mixed, including redirects near the address wrap.
    ack_pct = 60; stall_pct = 40; redir_pct = 10;
    repeat (1500) step();

    // Park a request at 0x40, then reset while it waits.
    ack_pct = 100; stall_pct = 0; redir_pct = 0;
    repeat (3) step();
    force_rpc = 32'h40; force_redir = 1'b1;
    step();
    ack_pct = 0;
    repeat (3) step();
    chk("midwait_req", 32'(bus.imem_req), 32'd1);
    chk("midwait_addr", bus.imem_addr, 32'h40);
    do_reset(1'b1);

    ack_pct = 70; stall_pct = 30; redir_pct = 15;
    repeat (1500) step();

    chk("progress", 32'(n_consumed > 500), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencing controller for the fetch stage of the pipelined RISC-V core. It owns the fetch PC and drives a request/acknowledge instruction-memory port. It presents fetched instructions to the fetch/decode pipeline register with a valid flag, applying stall from the hazard unit and branch/jump redirects from execute. A one-entry skid buffer and a discard state keep the memory handshake legal across stalls and flushes.

## Interface
- WIDTH, 32, address/instruction width
- RESET_PC, 32'h0, first fetch address after reset
- PC_STEP, 4, sequential PC increment
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- imem_req  output  1  instruction-memory request
- imem_addr  output  WIDTH  request address; stable while imem_req=1 and imem_ack=0
- imem_ack  input  1  response valid; may assert in the same cycle as imem_req
- imem_rdata  input  WIDTH  instruction, valid when imem_ack=1
- redirect_valid  input  1  taken branch/jump: flush fetch and restart at redirect_pc
- redirect_pc  input  WIDTH  redirect target
- stall  input  1  decode cannot accept; hold the output
- if_valid  output  1  if_pc/if_instr hold a valid instruction
- if_pc  output  WIDTH  PC of the presented instruction
- if_instr  output  WIDTH  presented instruction

## Operation
- Registers:
  - fetch_pc: address of the current or next request.
  - target_pc: pending redirect target.
  - skid_pc/skid_instr.
  - Output registers if_valid/if_pc/if_instr.
- State machine: BOOT, FETCH, HOLD, DISCARD. Reset value is BOOT.
- imem_req = 1 in FETCH and DISCARD, 0 otherwise. imem_addr = fetch_pc.
- The output is consumed in a cycle when if_valid=1 and stall=0.
- BOOT: imem_req=0; next state is FETCH.
- FETCH, ack and no redirect:
  - fetch_pc += PC_STEP (mod 2^WIDTH, wraps).
  - If the output is empty or consumed, load if_pc=fetch_pc, if_instr=imem_rdata, if_valid=1; stay in FETCH.
  - Otherwise load the skid and go to HOLD.
- FETCH, no ack: if the output is consumed, if_valid<=0.
- HOLD: imem_req=0. When stall=0, output<=skid, then FETCH.
- DISCARD: imem_req stays 1 with the old fetch_pc until ack. The ack data is dropped. Then fetch_pc<=target_pc and go to FETCH.
- Redirect has top priority and overrides stall:
  - if_valid<=0 and the skid is cleared.
  - In FETCH without same-cycle ack: target_pc<=redirect_pc, go to DISCARD.
  - In FETCH with same-cycle ack: data is dropped, fetch_pc<=redirect_pc, stay in FETCH.
  - In DISCARD: target_pc<=redirect_pc (latest wins). If ack arrives the same cycle, fetch_pc<=redirect_pc and go to FETCH.
  - In HOLD or BOOT: fetch_pc<=redirect_pc, go to FETCH.
- Reset (asynchronous, any time, including mid-request):
  - State BOOT, fetch_pc=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=0, skid cleared.
  - imem_req=0, imem_addr=RESET_PC.
  - A late ack after reset is ignored (controller is in BOOT).

## Timing
- imem_req/imem_addr are decoded from registered state only; there is no combinational path from any input.
- Ack in cycle n puts the instruction on if_* in cycle n+1 (one-cycle latency).
- With ack tied high, throughput is one instruction per cycle. Addresses are RESET_PC, +4, +8 …, with the first request in the cycle after BOOT.
- Redirect in cycle n, no outstanding wait: imem_addr=redirect_pc in n+1, and if_valid=0 in n+1.
- Redirect during a waiting request: the old address is held until ack (cycle m), and the target is issued in m+1.
- Stall never drops an instruction or issues a duplicate request; at most one instruction is buffered in the skid.

## Test plan
- Reset release, ack tied 1: imem_addr sequence 0,4,8,12. if_pc 0,4,8 appears one cycle after each ack, and if_valid stays 1 continuously.
- Ack delayed 3 cycles at addr 0x8: imem_addr stays 0x8 with req=1 for 3 cycles. if_valid=0 during the wait, then if_pc=0x8.
- Stall held 4 cycles while ack=1: if_pc/if_instr are frozen. One extra instruction goes to the skid and req=0 (HOLD). After release, the next outputs are the skid entry, then sequential PCs with no gap or duplicate.
- Redirect to 0x100 while a request to 0x20 waits 2 cycles: addr stays 0x20 until ack and 0x20 data is never shown. Next addr is 0x100, and if_valid=0 until the 0x100 data arrives.
- Redirect to 0x200 with stall=1 and a skid entry full: if_valid=0 next cycle, skid dropped, and the next request is 0x200.
- Reset asserted mid-wait at addr 0x40: outputs go to reset values immediately. After release, the first request is RESET_PC.
